step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pulse_gen_pkg.sv | 15 +
 rtl/step_pulse_gen_step_phase_ctr.sv | 41 ++++
 rtl/step_pulse_gen.sv | 109 ++++++++++
 tb/tb_step_pulse_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/step_pulse_gen_pkg.sv
// Shared definitions for the step pulse generator: FSM state encoding and
// default widths for the period and pulse-count datapaths.
package step_pulse_gen_pkg;

   localparam int DEF_WIDTH_TR  = 16;
   localparam int DEF_WIDTH_CNT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/step_pulse_gen_step_phase_ctr.sv
// Phase counter and step shaper: counts 0..period-1, drives step high for the
// last floor(period/2) phases and flags the final phase as the pulse boundary.
module step_phase_ctr
   import step_pulse_gen_pkg::*;
#(
   parameter int WIDTH_TR = DEF_WIDTH_TR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [WIDTH_TR-1:0] period,
   output logic                step,
   output logic                boundary
);

   logic [WIDTH_TR-1:0] ph;
   logic [WIDTH_TR-1:0] ph_inc;
   logic [WIDTH_TR-1:0] high_start;

   always_comb begin
      ph_inc     = ph + WIDTH_TR'(1);
      high_start = period - (period >> 1);
      boundary   = (ph == (period - WIDTH_TR'(1)));
   end

   // step is computed from the next phase so the registered output lines up
   // with ph; the wrap phase 0 is always in the low half for period >= 2.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         ph   <= '0;
         step <= 1'b0;
      end else if (boundary) begin
         ph   <= '0;
         step <= 1'b0;
      end else begin
         ph   <= ph_inc;
         step <= (ph_inc >= high_start);
      end
   end

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for a stepper driver: free-running or counted
// runs with period and direction changes applied only at pulse boundaries.
module step_pulse_gen
   import step_pulse_gen_pkg::*;
#(
   parameter int WIDTH_TR  = DEF_WIDTH_TR,
   parameter int WIDTH_CNT = DEF_WIDTH_CNT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 drv_en,
   input  logic                 dir,
   input  logic                 counter_en,
   input  logic [WIDTH_TR-1:0]  period,
   input  logic [WIDTH_CNT-1:0] pulse_target,
   output logic                 step,
   output logic                 dir_out,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH_CNT-1:0] pulse_cnt
);

   state_t               state;
   state_t               state_next;
   logic [WIDTH_TR-1:0]  p_reg;
   logic [WIDTH_CNT-1:0] cnt_inc;
   logic                 boundary;
   logic                 period_ok;
   logic                 entering_run;
   logic                 staying_run;
   logic                 leaving_idle;
   logic                 pulse_done;

   step_phase_ctr #(
      .WIDTH_TR (WIDTH_TR)
   ) u_phase (
      .clk      (clk),
      .rst      (rst),
      .enable   (staying_run),
      .period   (p_reg),
      .step     (step),
      .boundary (boundary)
   );

   // Next-state logic; drv_en low overrides everything and returns to IDLE.
   always_comb begin
      state_next = state;
      cnt_inc    = pulse_cnt + WIDTH_CNT'(1);
      period_ok  = (period >= WIDTH_TR'(2));
      if (!drv_en) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (counter_en && (pulse_target == '0))
                  state_next = ST_DONE;
               else if (period_ok)
                  state_next = ST_RUN;
            end
            ST_RUN: begin
               if (boundary) begin
                  if (counter_en && (cnt_inc == pulse_target))
                     state_next = ST_DONE;
                  else if (!period_ok)
                     state_next = ST_IDLE;
               end
            end
            ST_DONE: state_next = ST_HOLD;
            ST_HOLD: begin
               if (!counter_en)
                  state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      entering_run = (state != ST_RUN) && (state_next == ST_RUN);
      staying_run  = (state == ST_RUN) && (state_next == ST_RUN);
      leaving_idle = (state == ST_IDLE) && (state_next != ST_IDLE);
      pulse_done   = (state == ST_RUN) && boundary && drv_en;
   end

   // Period and direction are only sampled at run entry or a completed pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         dir_out   <= 1'b0;
         p_reg     <= '0;
         pulse_cnt <= '0;
      end else begin
         state <= state_next;
         busy  <= (state_next == ST_RUN);
         done  <= (state_next == ST_DONE);
         if (leaving_idle)
            pulse_cnt <= '0;
         else if (pulse_done)
            pulse_cnt <= cnt_inc;
         if (entering_run || pulse_done) begin
            p_reg   <= period;
            dir_out <= dir;
         end
      end
   end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed self-checking bench for step_pulse_gen: counted, free-run, boundary
// re-latch, zero-pulse, abort and reset-mid-run scenarios.
module tb_step_pulse_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        drv_en;
   logic        dir;
   logic        counter_en;
   logic [15:0] period;
   logic [15:0] pulse_target;
   logic        step;
   logic        dir_out;
   logic        busy;
   logic        done;
   logic [15:0] pulse_cnt;

   int check_count = 0;
   int error_count = 0;

   step_pulse_gen #(
      .WIDTH_TR  (16),
      .WIDTH_CNT (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .drv_en       (drv_en),
      .dir          (dir),
      .counter_en   (counter_en),
      .period       (period),
      .pulse_target (pulse_target),
      .step         (step),
      .dir_out      (dir_out),
      .busy         (busy),
      .done         (done),
      .pulse_cnt    (pulse_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic en, input logic d, input logic cen,
                                 input logic [15:0] p, input logic [15:0] tgt);
      drv_en       = en;
      dir          = d;
      counter_en   = cen;
      period       = p;
      pulse_target = tgt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag, input logic [15:0] cnt);
      check_output({tag, "_step"}, 32'(step), 32'(0));
      check_output({tag, "_busy"}, 32'(busy), 32'(0));
      check_output({tag, "_done"}, 32'(done), 32'(0));
      check_output({tag, "_cnt"},  32'(pulse_cnt), 32'(cnt));
   endtask

   initial begin
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      tick();
      check_idle_outputs("reset", 16'd0);
      check_output("reset_dir", 32'(dir_out), 32'(0));
      rst = 1'b0;

      // Counted run: P=4, target=3
      $display("[TB] counted run P=4 target=3");
      apply_stimulus(1'b1, 1'b1, 1'b1, 16'd4, 16'd3);
      for (int i = 0; i < 12; i++) begin
         tick();
         check_output("cnt4_step", 32'(step), 32'((i % 4) >= 2));
         check_output("cnt4_busy", 32'(busy), 32'(1));
         check_output("cnt4_pcnt", 32'(pulse_cnt), 32'(i / 4));
         check_output("cnt4_done", 32'(done), 32'(0));
      end
      check_output("cnt4_dir", 32'(dir_out), 32'(1));
      tick();
      check_output("cnt4_done_strobe", 32'(done), 32'(1));
      check_output("cnt4_done_busy", 32'(busy), 32'(0));
      check_output("cnt4_done_step", 32'(step), 32'(0));
      check_output("cnt4_done_cnt", 32'(pulse_cnt), 32'(3));
      tick();
      check_idle_outputs("cnt4_hold1", 16'd3);
      tick();
      check_idle_outputs("cnt4_hold2", 16'd3);
      apply_stimulus(1'b0, 1'b0, 1'b0, 16'd4, 16'd3);
      tick();
      check_idle_outputs("cnt4_idle", 16'd3);

      // Free-run P=5, then drv_en drops exactly at a boundary
      $display("[TB] free-run P=5");
      apply_stimulus(1'b1, 1'b0, 1'b0, 16'd5, 16'd0);
      for (int i = 0; i < 15; i++) begin
         tick();
         check_output("free5_step", 32'(step), 32'((i % 5) >= 3));
         check_output("free5_busy", 32'(busy), 32'(1));
         check_output("free5_pcnt", 32'(pulse_cnt), 32'(i / 5));
      end
      check_output("free5_dir", 32'(dir_out), 32'(0));
      drv_en = 1'b0;
      tick();
      check_idle_outputs("free5_abort", 16'd2);

      // Period 4->6 and dir change mid-pulse, then period 1 forces IDLE
      $display("[TB] boundary re-latch");
      apply_stimulus(1'b1, 1'b0, 1'b0, 16'd4, 16'd0);
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i < 4) begin
            check_output("relatch_step", 32'(step), 32'(i >= 2));
            check_output("relatch_dir", 32'(dir_out), 32'(0));
         end else begin
            check_output("relatch_step", 32'(step), 32'(((i - 4) % 6) >= 3));
            check_output("relatch_dir", 32'(dir_out), 32'(1));
         end
         check_output("relatch_busy", 32'(busy), 32'(1));
         if (i == 1) begin
            dir    = 1'b1;
            period = 16'd6;
         end
         if (i == 10) begin
            check_output("relatch_pcnt", 32'(pulse_cnt), 32'(2));
            period = 16'd1;
         end
      end
      tick();
      check_idle_outputs("short_period_idle", 16'd3);
      check_output("short_period_dir", 32'(dir_out), 32'(1));
      tick();
      check_idle_outputs("short_period_stay", 16'd3);

      // Zero-pulse counted run
      $display("[TB] zero-pulse run");
      apply_stimulus(1'b1, 1'b0, 1'b1, 16'd1, 16'd0);
      tick();
      check_output("zero_done", 32'(done), 32'(1));
      check_output("zero_step", 32'(step), 32'(0));
      check_output("zero_busy", 32'(busy), 32'(0));
      check_output("zero_cnt", 32'(pulse_cnt), 32'(0));
      tick();
      check_idle_outputs("zero_hold", 16'd0);
      drv_en = 1'b0;
      tick();

      // Abort at ph=2 of pulse 2 in a counted run
      $display("[TB] abort mid-pulse");
      apply_stimulus(1'b1, 1'b0, 1'b1, 16'd4, 16'd5);
      for (int i = 0; i < 7; i++) begin
         tick();
         check_output("abort_step", 32'(step), 32'((i % 4) >= 2));
         check_output("abort_busy", 32'(busy), 32'(1));
      end
      drv_en = 1'b0;
      tick();
      check_idle_outputs("abort_idle", 16'd1);
      tick();
      check_idle_outputs("abort_idle2", 16'd1);

      // Reset mid-run, then restart from phase 0
      $display("[TB] reset mid-run");
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'd4, 16'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_output("prerst_step", 32'(step), 32'((i % 4) >= 2));
      end
      rst = 1'b1;
      tick();
      check_idle_outputs("midrst", 16'd0);
      check_output("midrst_dir", 32'(dir_out), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_output("restart_step", 32'(step), 32'(i >= 2));
         check_output("restart_busy", 32'(busy), 32'(1));
         check_output("restart_dir", 32'(dir_out), 32'(1));
      end

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
